seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Scan controller for the board's multiplexed 7-segment display. Generates its own refresh tick,
//   sequences one digit at a time, and decodes hex nibbles to active-low segment patterns.
//   Accepts new display contents over a valid/ready handshake and applies them only at frame end,
//   so a frame never shows a mix of old and new digits.
//   Sits between the CPU's MMIO display register and the seg/anode pins.
// PARAMETERS
//   NUM_DIGITS  8       number of digits scanned; digit 0 = rightmost
//   TICK_DIV    100000  clk cycles per digit slot; legal range >= 3
// PORTS
//   clk        in   1               system clock
//   rst        in   1               synchronous, active-high reset
//   enable     in   1               1 = scan display, 0 = display dark
//   lz_en      in   1               1 = suppress leading zeros
//   wr_valid   in   1               new display data offered
//   wr_ready   out  1               controller can accept data (= !pending)
//   wr_data    in   4*NUM_DIGITS    hex nibbles; [3:0] = digit 0
//   wr_dp      in   NUM_DIGITS      decimal point per digit, 1 = lit
//   seg_en     out  NUM_DIGITS      anode enables, active-low
//   seg_out    out  8               {dp,g,f,e,d,c,b,a}, active-low
//   frame_done out  1               1-cycle pulse at end of each scanned frame
// BEHAVIOUR
// - Reset (rst=1 at a clk edge) sets: state=OFF, cnt=0, idx=0, active data/dp=0, pending=0.
//   Outputs after reset: seg_en='1, seg_out=8'hFF, frame_done=0, wr_ready=1.
//   Any pending write is discarded.
// - Handshake: a write is accepted when wr_valid & wr_ready on a clk edge.
//   On accept, wr_data/wr_dp are latched into the shadow register and pending is set.
//   wr_ready is combinational !pending, so a second write stalls until commit.
// - Commit (shadow -> active, pending cleared):
//   - In OFF: on the cycle after accept.
//   - In SCAN: only on the frame-end cycle.
//   - If an accept and a frame end coincide, that data is committed at the following frame end.
// - FSM OFF:
//   - cnt=0, idx=0, seg_en='1, seg_out=8'hFF.
//   - enable=1 moves to SCAN on the next edge; slot for idx 0 starts with cnt=0.
// - FSM SCAN:
//   - cnt counts 0..TICK_DIV-1 and wraps. tick = (cnt==TICK_DIV-1).
//   - On tick, idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
//   - Frame end = tick & idx==NUM_DIGITS-1. frame_done is registered and high on the cycle after frame end.
//   - enable=0 moves to OFF on the next edge; outputs go dark that same edge and the frame is abandoned.
// - Slot timing:
//   - Outputs are registered from (state, cnt, idx, active).
//   - In each slot's first cycle (cnt==0), the guard cycle applies: seg_en='1 and seg_out=8'hFF (anti-ghosting).
//   - For cnt 1..TICK_DIV-1: seg_en has only bit idx low, and seg_out is the decoded digit.
//   - Outputs therefore lag cnt/idx by one clk.
// - Decode (active-low, dp off):
//   0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
//   - seg_out[7] = ~dp[idx].
// - Leading-zero suppression (lz_en=1):
//   - Digit i>0 is blanked (seg_en stays all-1, seg_out=FF) if it and all higher nibbles are 0 and dp[i]=0.
//   - Digit 0 is always shown. The slot is still consumed, so timing is unchanged.
// - lz_en and enable are sampled every cycle. No other input is sampled outside the handshake.
// TESTING (TICK_DIV=4, NUM_DIGITS=8 in bench)
// 1. Hold rst 2 cycles mid-scan with pending=1:
//    -> seg_en=FF, seg_out=FF, wr_ready=1, frame_done=0; a new frame shows all "0" (C0).
// 2. In OFF, write 32'h0000_0012 with dp=0, then enable=1, lz_en=0:
//    -> digit0 slot shows A4 with seg_en=FE for 3 cycles after a 1-cycle FF guard;
//       digit1 F9 with seg_en=FD; digits 2-7 C0.
// 3. Same data with lz_en=1:
//    -> digits 2-7 slots keep seg_en=FF; frame_done still pulses every 32 cycles.
// 4. Mid-frame (idx=3), write 32'h8888_8888:
//    -> wr_ready=0, display unchanged through idx 7; a second wr_valid is not accepted;
//       after frame_done, digit0 shows 80; wr_ready=1 again.
// 5. Drop enable at idx=5, cnt=2:
//    -> next edge seg_en=FF, seg_out=FF; re-enable -> scan resumes at idx 0 with a guard cycle.
// 6. Assert wr_valid exactly on the frame-end cycle:
//    -> accepted, wr_ready=0, committed only at the next frame end (32 cycles later).

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: self-timed digit slots, hex decode, leading-zero
// blanking, and a shadow/active register pair so new contents only appear at frame boundaries.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    lz_en,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  output logic [NUM_DIGITS-1:0]   seg_en,
  output logic [7:0]              seg_out,
  output logic                    frame_done,
  output logic                    dbg_scan
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {ST_OFF, ST_SCAN} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d, sh_data_q, sh_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic                    pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   seg_en_q, seg_en_d;
  logic [7:0]              seg_out_q, seg_out_d;
  logic                    frame_done_q;

  logic tick, last, frame_end, accept, commit;
  logic [3:0] nib;
  logic dp_bit, upper_zero, blank;
  logic [NUM_DIGITS-1:0] one_hot;

  // Active-low {g,f,e,d,c,b,a}; the dp bit is added by the caller.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Handshake: a write transfers on any clk edge where wr_valid & wr_ready; wr_ready is
  // simply !pending, so the offer must be held until the previous one has been committed.
  assign wr_ready  = !pend_q;
  assign accept    = wr_valid && !pend_q;
  assign tick      = (cnt_q == CW'(TICK_DIV - 1));
  assign last      = (idx_q == IW'(NUM_DIGITS - 1));
  assign frame_end = (state_q == ST_SCAN) && enable && tick && last;
  assign commit    = pend_q && ((state_q == ST_OFF) || frame_end);

  assign seg_en     = seg_en_q;
  assign seg_out    = seg_out_q;
  assign frame_done = frame_done_q;
  assign dbg_scan   = (state_q == ST_SCAN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        idx_d = '0;
        if (enable) state_d = ST_SCAN;
      end
      default: begin
        if (!enable) begin
          state_d = ST_OFF;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (tick) begin
          cnt_d = '0;
          idx_d = last ? '0 : idx_q + IW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_comb begin
    pend_d     = pend_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    if (accept) begin
      pend_d    = 1'b1;
      sh_data_d = wr_data;
      sh_dp_d   = wr_dp;
    end else if (commit) begin
      pend_d     = 1'b0;
      act_data_d = sh_data_q;
      act_dp_d   = sh_dp_q;
    end
  end

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    nib        = act_data_q[idx_q*4 +: 4];
    dp_bit     = act_dp_q[idx_q];
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (IW'(j) >= idx_q && act_data_q[j*4 +: 4] != 4'h0) upper_zero = 1'b0;
    end
    blank = lz_en && (idx_q != '0) && upper_zero && !dp_bit;
  end

  // cnt==0 is the anti-ghosting guard cycle; the enable term darkens the pins on the same
  // edge that leaves SCAN.
  always_comb begin
    one_hot        = '0;
    one_hot[idx_q] = 1'b1;
    seg_en_d       = '1;
    seg_out_d      = 8'hFF;
    if (state_q == ST_SCAN && enable && cnt_q != '0 && !blank) begin
      seg_en_d  = ~one_hot;
      seg_out_d = {~dp_bit, hex7(nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      pend_q       <= 1'b0;
      seg_en_q     <= '1;
      seg_out_q    <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      pend_q       <= pend_d;
      seg_en_q     <= seg_en_d;
      seg_out_q    <= seg_out_d;
      frame_done_q <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (8 digits, 4-cycle slots): each lit digit slot is checked against a
// queue of hand-computed {length, anodes, segments} entries; handshake and timing checked inline.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, enable, lz_en, wr_valid;
  logic        wr_ready, frame_done, dbg_scan;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp, seg_en, seg_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [19:0] exp_q[$];
  bit          mon_on  = 1'b0;
  bit          in_slot = 1'b0;
  logic [7:0]  cap_en, cap_out;
  int          cap_len;
  int          c0, c1, c2, c3, c4, c5;

  seg_scan_ctrl #(.NUM_DIGITS(8), .TICK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .lz_en      (lz_en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .seg_en     (seg_en),
    .seg_out    (seg_out),
    .frame_done (frame_done),
    .dbg_scan   (dbg_scan)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", {31'b0, frame_done}, 32'd1);
    c = cyc;
  endtask

  task automatic push_slot(input int d, input logic [7:0] seg, input int len);
    logic [7:0] en;
    logic [3:0] l;
    en    = 8'hFF;
    en[d] = 1'b0;
    l     = len[3:0];
    exp_q.push_back({l, en, seg});
  endtask

  task automatic push_frame_all(input logic [7:0] seg);
    for (int d = 0; d < 8; d++) push_slot(d, seg, 3);
  endtask

  // scoreboard monitor: a slot is a run of identical non-dark outputs
  task automatic close_slot();
    logic [19:0] got, e;
    logic [3:0]  l;
    l   = cap_len[3:0];
    got = {l, cap_en, cap_out};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL slot_unexpected: got len=%0d en=%h seg=%h, required no slot (cycle %0d)",
               cap_len, cap_en, cap_out, cyc);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_err++;
        $display("FAIL slot: got len=%0d en=%h seg=%h, required len=%0d en=%h seg=%h (cycle %0d)",
                 cap_len, cap_en, cap_out, e[19:16], e[15:8], e[7:0], cyc);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (seg_en !== 8'hFF) begin
          if (!in_slot) begin
            in_slot = 1'b1;
            cap_en  = seg_en;
            cap_out = seg_out;
            cap_len = 1;
          end else if (seg_en === cap_en && seg_out === cap_out) begin
            cap_len++;
          end else begin
            close_slot();
            cap_en  = seg_en;
            cap_out = seg_out;
            cap_len = 1;
          end
        end else if (in_slot) begin
          close_slot();
          in_slot = 1'b0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; lz_en = 1'b0; wr_valid = 1'b0;
    wr_data = 32'h0; wr_dp = 8'h0;
    step(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_seg_en", {24'b0, seg_en}, 32'hFF);
    chk("rst_seg_out", {24'b0, seg_out}, 32'hFF);
    chk("rst_wr_ready", {31'b0, wr_ready}, 32'd1);

    // reset mid-scan with a write pending
    enable = 1'b1;
    step(10);
    wr_valid = 1'b1; wr_data = 32'h1234_5678; wr_dp = 8'hFF;
    step(1);
    wr_valid = 1'b0;
    @(negedge clk);
    chk("pend_before_rst", {31'b0, wr_ready}, 32'd0);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_seg_en", {24'b0, seg_en}, 32'hFF);
    chk("rst2_seg_out", {24'b0, seg_out}, 32'hFF);
    chk("rst2_wr_ready", {31'b0, wr_ready}, 32'd1);
    chk("rst2_frame_done", {31'b0, frame_done}, 32'd0);
    push_frame_all(8'hC0);
    mon_on = 1'b1;
    wait_fd(c0);

    // go dark, write 0x12 while OFF
    step(1);
    enable = 1'b0;
    step(1);
    @(negedge clk);
    chk("off_state", {31'b0, dbg_scan}, 32'd0);
    chk("off_frame_done", {31'b0, frame_done}, 32'd0);
    chk("off_wr_ready", {31'b0, wr_ready}, 32'd1);
    wr_valid = 1'b1; wr_data = 32'h0000_0012; wr_dp = 8'h00;
    step(1);
    wr_valid = 1'b0;
    @(negedge clk);
    chk("off_accept_ready", {31'b0, wr_ready}, 32'd0);
    step(1);
    @(negedge clk);
    chk("off_commit_ready", {31'b0, wr_ready}, 32'd1);
    push_slot(0, 8'hA4, 3);
    push_slot(1, 8'hF9, 3);
    for (int d = 2; d < 8; d++) push_slot(d, 8'hC0, 3);
    enable = 1'b1;
    wait_fd(c0);

    // leading-zero suppression: only digits 0 and 1 light
    step(1);
    lz_en = 1'b1;
    push_slot(0, 8'hA4, 3);
    push_slot(1, 8'hF9, 3);
    wait_fd(c1);
    chk("frame_period_lz", c1 - c0, 32'd32);

    // write mid-frame at idx 3; second offer must stall
    step(1);
    lz_en = 1'b0;
    push_slot(0, 8'hA4, 3);
    push_slot(1, 8'hF9, 3);
    for (int d = 2; d < 8; d++) push_slot(d, 8'hC0, 3);
    step(12);
    wr_valid = 1'b1; wr_data = 32'h8888_8888; wr_dp = 8'h00;
    step(1);
    wr_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("mid_ready_low", {31'b0, wr_ready}, 32'd0);
    step(5);
    wr_valid = 1'b0;
    @(negedge clk);
    chk("mid_ready_still_low", {31'b0, wr_ready}, 32'd0);
    for (int d = 0; d < 5; d++) push_slot(d, 8'h80, 3);
    push_slot(5, 8'h80, 1);
    wait_fd(c2);
    chk("frame_period_mid", c2 - c1, 32'd32);
    chk("commit_ready_high", {31'b0, wr_ready}, 32'd1);

    // drop enable at idx 5 cnt 2, then resume
    step(22);
    enable = 1'b0;
    step(1);
    @(negedge clk);
    chk("drop_seg_en", {24'b0, seg_en}, 32'hFF);
    chk("drop_seg_out", {24'b0, seg_out}, 32'hFF);
    step(3);
    push_frame_all(8'h80);
    enable = 1'b1;
    step(2);
    @(negedge clk);
    chk("resume_guard", {24'b0, seg_en}, 32'hFF);
    step(1);
    @(negedge clk);
    chk("resume_digit0_en", {24'b0, seg_en}, 32'hFE);
    chk("resume_digit0_seg", {24'b0, seg_out}, 32'h80);
    wait_fd(c3);

    // write offered exactly on the frame-end edge
    push_frame_all(8'h80);
    push_frame_all(8'h80);
    push_slot(0, 8'h92, 3);
    push_slot(1, 8'h08, 3);
    for (int d = 2; d < 8; d++) push_slot(d, 8'hC0, 3);
    step(31);
    wr_valid = 1'b1; wr_data = 32'h0000_00A5; wr_dp = 8'h02;
    step(1);
    wr_valid = 1'b0;
    @(negedge clk);
    chk("fe_coincide_fd", {31'b0, frame_done}, 32'd1);
    chk("fe_accept_ready", {31'b0, wr_ready}, 32'd0);
    step(16);
    @(negedge clk);
    chk("fe_hold_ready", {31'b0, wr_ready}, 32'd0);
    wait_fd(c4);
    chk("fe_commit_ready", {31'b0, wr_ready}, 32'd1);
    wait_fd(c5);
    chk("frame_period_fe", c5 - c4, 32'd32);

    step(1);
    enable = 1'b0;
    step(3);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("no_open_slot", {31'b0, in_slot}, 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
